// File: rtl/banked_code_rom.sv
// Loadable banked program ROM: BANKS banks of 2^AW words, filled through a
// byte-stream load port, read by the CPU through a registered one-cycle port.
`timescale 1ns/1ps
module banked_code_rom #(
   parameter int unsigned BANKS = 4,
   parameter int unsigned AW    = 13,
   parameter int unsigned DW    = 8
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [AW-1:0]    a,
   input  logic [BANKS-1:0] ce_n,
   output logic [DW-1:0]    out,
   output logic             wait_n,
   input  logic             ld_start,
   input  logic [DW-1:0]    ld_data,
   input  logic             ld_valid,
   output logic             ld_ready,
   output logic             ld_done,
   output logic [15:0]      ld_sum
);

   localparam int unsigned BW    = $clog2(BANKS);
   localparam int unsigned PW    = AW + BW;
   localparam int unsigned Words = BANKS << AW;

   typedef enum logic [1:0] {StEmpty, StLoad, StDone} state_e;

   state_e          state_q, state_d;
   logic [PW-1:0]   ptr_q, ptr_d;
   logic [15:0]     sum_q, sum_d;
   logic [DW-1:0]   out_q, out_d;
   logic [DW-1:0]   mem [Words];
   logic [BW-1:0]   sel;
   logic            any_ce;
   logic            xfer;

   // A restart in the same cycle as a valid word swallows that word.
   assign xfer = ld_valid & ld_ready & ~ld_start;

   // State and datapath registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= StEmpty;
         ptr_q   <= '0;
         sum_q   <= '0;
         out_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         sum_q   <= sum_d;
         out_q   <= out_d;
      end
   end

   // Image storage; contents survive reset and are gated by the DONE state.
   always_ff @(posedge clk) begin
      if (xfer) begin
         mem[ptr_q] <= ld_data;
      end
   end

   // Next state: restart from anywhere, finish on the last accepted word.
   always_comb begin
      state_d = state_q;
      case (state_q)
         StLoad: if (xfer && ptr_q == {PW{1'b1}}) state_d = StDone;
         default: ;
      endcase
      if (ld_start) state_d = StLoad;
   end

   // Write pointer and running checksum.
   always_comb begin
      ptr_d = ptr_q;
      sum_d = sum_q;
      if (ld_start) begin
         ptr_d = '0;
         sum_d = '0;
      end else if (xfer) begin
         ptr_d = ptr_q + PW'(1);
         sum_d = sum_q + 16'(ld_data);
      end
   end

   // Lowest-index asserted chip enable selects the bank.
   always_comb begin
      sel = '0;
      for (int i = BANKS - 1; i >= 0; i--) begin
         if (!ce_n[i]) sel = BW'(i);
      end
      any_ce = ~&ce_n;
   end

   // Read data for the next edge; zero unless a valid image is present.
   always_comb begin
      out_d = '0;
      if (state_q == StDone && any_ce) out_d = mem[{sel, a}];
   end

   // State-decoded outputs.
   always_comb begin
      ld_ready = (state_q == StLoad);
      ld_done  = (state_q == StDone);
      wait_n   = ~(any_ce && state_q != StDone);
   end

   assign out    = out_q;
   assign ld_sum = sum_q;

endmodule
